bit_scan_iterator: RTL and testbench

BIT_SCAN_ITERATOR -- requirements
Module: bit_scan_iterator

---
 rtl/bit_scan_pkg.sv | 30 +++
 rtl/bit_pick.sv | 35 +++
 rtl/bit_scan_iterator.sv | 109 ++++++++++
 tb/tb_bit_scan_iterator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_scan_pkg.sv
// rtl/bit_scan_pkg.sv - shared types and helpers for the bit scan iterator
// Contents:
//   state_t        : controller state (IDLE accepts a word, SCAN emits beats)
//   MAX_W          : widest supported input word
//   MAX_IDX_W      : index width for MAX_W
//   onehot_to_idx  : binary index of a one-hot word (zero-extended to MAX_W)
package bit_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int MAX_W     = 64;
    localparam int MAX_IDX_W = 6;

    // OR-reduction of the indices of all set bits; exact for a one-hot or
    // all-zero input, which is all the iterator ever feeds it.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_W-1:0] onehot);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (onehot[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bit_pick.sv
// rtl/bit_pick.sv - combinational lowest/highest set bit selector
// Ports:
//   word   : input word to scan
//   dir    : 0 selects the lowest set bit, 1 selects the highest set bit
//   onehot : one-hot of the selected bit, all-zero when word is all-zero
module bit_pick #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] word,
    input  logic             dir,
    output logic [WIDTH-1:0] onehot
);

    // The loop runs away from the wanted end so the last match, which is the
    // one that survives, is the bit closest to that end.
    always_comb begin
        onehot = '0;
        if (!dir) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (word[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (word[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bit_scan_iterator.sv
// rtl/bit_scan_iterator.sv - emits one beat per set bit of an accepted word
// Ports:
//   clk_i, srst_i        : clock and synchronous active-high reset
//   data_val_i, data_i,
//   dir_i, data_ready_o  : input word handshake, dir 0 = LSB-first, 1 = MSB-first
//   data_onehot_o,
//   data_idx_o           : current set bit as one-hot and binary index
//   data_zero_o          : accepted word was all-zero
//   data_last_o          : current beat is the final beat of the word
//   data_val_o,
//   data_ready_i         : output beat handshake
module bit_scan_iterator #(
    parameter int WIDTH = 5,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             data_val_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] data_onehot_o,
    output logic [IDX_W-1:0] data_idx_o,
    output logic             data_zero_o,
    output logic             data_last_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);

    import bit_scan_pkg::*;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_next;
    logic             dir_q;
    logic             dir_next;
    logic             zero_q;
    logic             zero_next;

    logic [WIDTH-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_last;

    bit_pick #(
        .WIDTH (WIDTH)
    ) u_bit_pick (
        .word   (rem),
        .dir    (dir_q),
        .onehot (pick)
    );

    assign pick_idx  = IDX_W'(onehot_to_idx(MAX_W'(pick)));
    // Clearing the lowest set bit leaves nothing when at most one bit is set.
    assign pick_last = (rem & (rem - WIDTH'(1))) == '0;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state  <= IDLE;
            rem    <= '0;
            dir_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_next;
            rem    <= rem_next;
            dir_q  <= dir_next;
            zero_q <= zero_next;
        end
    end

    always_comb begin
        state_next    = state;
        rem_next      = rem;
        dir_next      = dir_q;
        zero_next     = zero_q;
        data_ready_o  = 1'b0;
        data_val_o    = 1'b0;
        data_onehot_o = '0;
        data_idx_o    = '0;
        data_zero_o   = 1'b0;
        data_last_o   = 1'b0;
        case (state)
            IDLE: begin
                data_ready_o = 1'b1;
                if (data_val_i) begin
                    rem_next   = data_i;
                    dir_next   = dir_i;
                    zero_next  = (data_i == '0);
                    state_next = SCAN;
                end
            end
            SCAN: begin
                data_val_o    = 1'b1;
                data_onehot_o = pick;
                data_idx_o    = pick_idx;
                data_zero_o   = zero_q;
                data_last_o   = pick_last;
                if (data_ready_i) begin
                    rem_next = rem & ~pick;
                    if (pick_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bit_scan_iterator.sv
// tb/tb_bit_scan_iterator.sv - scoreboard bench for bit_scan_iterator
module tb_bit_scan_iterator;

    localparam int W  = 5;
    localparam int IW = 3;

    logic          clk_i = 1'b0;
    logic          srst_i;
    logic          data_val_i;
    logic [W-1:0]  data_i;
    logic          dir_i;
    logic          data_ready_o;
    logic [W-1:0]  data_onehot_o;
    logic [IW-1:0] data_idx_o;
    logic          data_zero_o;
    logic          data_last_o;
    logic          data_val_o;
    logic          data_ready_i;

    bit_scan_iterator #(
        .WIDTH (W)
    ) dut (
        .clk_i         (clk_i),
        .srst_i        (srst_i),
        .data_val_i    (data_val_i),
        .data_i        (data_i),
        .dir_i         (dir_i),
        .data_ready_o  (data_ready_o),
        .data_onehot_o (data_onehot_o),
        .data_idx_o    (data_idx_o),
        .data_zero_o   (data_zero_o),
        .data_last_o   (data_last_o),
        .data_val_o    (data_val_o),
        .data_ready_i  (data_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0]  onehot;
        logic [IW-1:0] idx;
        logic          zero;
        logic          last;
    } beat_t;

    beat_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   last_cyc = 0;
    bit   mon_en = 1'b0;
    bit   rand_mode = 1'b0;
    logic ready_force = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Reference: list the set bit positions, order them by direction, one beat each.
    function automatic void push_expected(input logic [W-1:0] w, input logic d);
        int    pos[$];
        beat_t b;
        for (int i = 0; i < W; i++) begin
            if (w[i]) begin
                if (d) pos.push_front(i);
                else   pos.push_back(i);
            end
        end
        if (pos.size() == 0) begin
            b.onehot = '0;
            b.idx    = '0;
            b.zero   = 1'b1;
            b.last   = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int j = 0; j < pos.size(); j++) begin
                b.onehot         = '0;
                b.onehot[pos[j]] = 1'b1;
                b.idx            = IW'(pos[j]);
                b.zero           = 1'b0;
                b.last           = (j == pos.size() - 1);
                exp_q.push_back(b);
            end
        end
    endfunction

    initial begin
        data_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            data_ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    logic [9:0] snap;
    bit         hold_v = 1'b0;

    always @(negedge clk_i) begin : monitor
        beat_t e;
        if (mon_en) begin
            if (data_val_o) begin
                check("busy_ready", data_ready_o, 1'b0);
                if (hold_v) begin
                    check("stall_hold", {data_onehot_o, data_idx_o, data_zero_o, data_last_o}, snap);
                end
                if (data_ready_i) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_onehot", data_onehot_o, e.onehot);
                        check("beat_idx", data_idx_o, e.idx);
                        check("beat_zero", data_zero_o, e.zero);
                        check("beat_last", data_last_o, e.last);
                        if (e.last) last_cyc = cyc + 1;
                    end
                end else begin
                    snap   = {data_onehot_o, data_idx_o, data_zero_o, data_last_o};
                    hold_v = 1'b1;
                end
            end else begin
                hold_v = 1'b0;
                check("idle_ready", data_ready_o, 1'b1);
                check("idle_outputs", {data_onehot_o, data_idx_o, data_zero_o, data_last_o}, 10'd0);
            end
        end
    end

    // Called and returns just after a rising edge; leaves data_val_i high.
    task automatic send(input logic [W-1:0] w, input logic d);
        int   n = 0;
        logic hs = 1'b0;
        push_expected(w, d);
        data_i     = w;
        dir_i      = d;
        data_val_i = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk_i);
            hs = data_ready_o && !srst_i;
            if (hs) hs_cyc = cyc + 1;
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!hs) check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk_i);
            done = (exp_q.size() == 0) && data_ready_o;
            n++;
        end
        if (!done) check("idle_timeout", 0, 1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        srst_i     = 1'b1;
        data_val_i = 1'b0;
        data_i     = '0;
        dir_i      = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        srst_i = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_i);
        check("reset_ready", data_ready_o, 1'b1);
        check("reset_val", data_val_o, 1'b0);
        @(posedge clk_i);
        #1;

        ready_force = 1'b1;
        send(5'b10110, 1'b0);
        data_val_i = 1'b0;
        wait_idle();
        send(5'b10110, 1'b1);
        data_val_i = 1'b0;
        wait_idle();
        send(5'b00000, 1'b0);
        data_val_i = 1'b0;
        wait_idle();

        // First beat stalled for two SCAN cycles.
        ready_force = 1'b0;
        send(5'b11111, 1'b0);
        data_val_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            check("stall_first_onehot", {data_val_o, data_onehot_o}, 6'b1_00001);
            @(posedge clk_i);
            #1;
        end
        ready_force = 1'b1;
        @(negedge clk_i);
        check("stall_first_onehot", {data_val_o, data_onehot_o}, 6'b1_00001);
        @(posedge clk_i);
        #1;
        wait_idle();

        // Reset after two accepted beats discards the rest.
        send(5'b11111, 1'b0);
        data_val_i = 1'b0;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        ready_force = 1'b0;
        srst_i      = 1'b1;
        @(posedge clk_i);
        #1;
        srst_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        check("mid_reset_val", data_val_o, 1'b0);
        check("mid_reset_ready", data_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        ready_force = 1'b1;
        send(5'b00001, 1'b0);
        data_val_i = 1'b0;
        wait_idle();

        // Word held during SCAN is taken one cycle after the last beat.
        send(5'b00011, 1'b0);
        send(5'b01000, 1'b0);
        data_val_i = 1'b0;
        check("b2b_gap", hs_cyc, last_cyc + 1);
        wait_idle();

        rand_mode = 1'b1;
        for (int t = 0; t < 40; t++) begin
            r = $urandom;
            send(r[W-1:0], r[W]);
            data_val_i = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i);
                #1;
            end
        end
        rand_mode   = 1'b0;
        ready_force = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
